// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared definitions for the mux_arb slice: the mode encodings used on the
// mux_arb 'mode' input.
//   MODE_KEY : channel picked by the 'sel' key
//   MODE_RR  : channel picked by round-robin arbitration among valid inputs
package mux_arb_pkg;

    localparam logic MODE_KEY = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// ptr+1 and wrapping modulo NR_CH; the first set request wins.
// Ports:
//   req   in  NR_CH    request vector
//   ptr   in  SEL_LEN  index of the last winner (search starts just after it)
//   grant out SEL_LEN  index of the winning request (0 when none)
//   found out 1        at least one request was set
module rr_pick #(
    parameter int  NR_CH   = 4,
    localparam int SEL_LEN = $clog2(NR_CH)
) (
    input  logic [NR_CH-1:0]   req,
    input  logic [SEL_LEN-1:0] ptr,
    output logic [SEL_LEN-1:0] grant,
    output logic               found
);

    logic [SEL_LEN-1:0] cand;

    // Walk the candidates from farthest (ptr+NR_CH == ptr) to nearest
    // (ptr+1) so the last hit written is the one closest after ptr.
    // ptr is always a legal channel, so one subtraction handles the wrap.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = NR_CH; i >= 1; i--) begin
            if (int'(ptr) + i >= NR_CH)
                cand = SEL_LEN'(int'(ptr) + i - NR_CH);
            else
                cand = SEL_LEN'(int'(ptr) + i);
            if (req[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// mux_arb
// Registered N-channel multiplexer with valid/ready handshakes on every input
// and on the output. The channel is chosen either by the 'sel' key or by
// round-robin arbitration; the chosen word and its channel index are
// captured into an output buffer one cycle later.
// Build option: define MUX_ARB_SKID_EN for a two-entry skid buffer whose
// in_ready does not depend on out_ready; otherwise a single-entry buffer.
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   mode            0 = keyed select, 1 = round-robin
//   sel             channel key for keyed mode
//   in_valid        per-channel valid
//   in_ready        per-channel ready, one-hot or zero
//   in_data         flat input data, channel n at [DATA_LEN*(n+1)-1:DATA_LEN*n]
//   out_valid       output holds data
//   out_ready       consumer accepts
//   out_data        buffered data
//   out_ch          channel that supplied out_data
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int  NR_CH    = 4,
    parameter int  DATA_LEN = 2,
    localparam int SEL_LEN  = $clog2(NR_CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_LEN-1:0]        sel,
    input  logic [NR_CH-1:0]          in_valid,
    output logic [NR_CH-1:0]          in_ready,
    input  logic [NR_CH*DATA_LEN-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_LEN-1:0]       out_data,
    output logic [SEL_LEN-1:0]        out_ch
);

    logic [SEL_LEN-1:0]  ptr;
    logic [SEL_LEN-1:0]  rr_grant;
    logic                rr_found;
    logic [SEL_LEN-1:0]  grant;
    logic                found;
    logic [DATA_LEN-1:0] grant_data;
    logic                can_accept;
    logic                push;
    logic                pop;

    rr_pick #(.NR_CH(NR_CH)) u_rr_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .found (rr_found)
    );

    // A key that does not name an existing channel grants nothing.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (mode == MODE_KEY) begin
            grant = sel;
            found = (int'(sel) < NR_CH) && in_valid[sel];
        end else begin
            grant = rr_grant;
            found = rr_found;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int n = 0; n < NR_CH; n++) begin
            if (int'(grant) == n)
                grant_data = in_data[n*DATA_LEN +: DATA_LEN];
        end
    end

    assign pop  = out_valid & out_ready;
    assign push = found & can_accept;

    // rst_n gates can_accept so no transfer is offered while in reset.
    always_comb begin
        in_ready = '0;
        for (int n = 0; n < NR_CH; n++) begin
            in_ready[n] = push && (int'(grant) == n);
        end
    end

    // The pointer follows every input transfer regardless of mode, so a
    // mode switch resumes round-robin right after the last served channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= SEL_LEN'(NR_CH - 1);
        else if (push)
            ptr <= grant;
    end

`ifdef MUX_ARB_SKID_EN
    logic [1:0]          count;
    logic [DATA_LEN-1:0] skid_data;
    logic [SEL_LEN-1:0]  skid_ch;

    assign out_valid  = (count != 2'd0);
    assign can_accept = rst_n && (count != 2'd2);

    // out_data/out_ch are the head entry; skid_* holds the word that
    // arrived after the consumer stalled. Push with pop only occurs at
    // occupancy 1, since a full buffer refuses input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            out_data  <= '0;
            out_ch    <= '0;
            skid_data <= '0;
            skid_ch   <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        out_data <= grant_data;
                        out_ch   <= grant;
                        count    <= 2'd1;
                    end else begin
                        skid_data <= grant_data;
                        skid_ch   <= grant;
                        count     <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        out_data <= skid_data;
                        out_ch   <= skid_ch;
                        count    <= 2'd1;
                    end else begin
                        count <= 2'd0;
                    end
                end
                2'b11: begin
                    out_data <= grant_data;
                    out_ch   <= grant;
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic full;

    assign out_valid  = full;
    assign can_accept = rst_n && (!full || out_ready);

    // Single entry: a push overwrites the entry (which is leaving this
    // cycle if it was full); otherwise a pop empties it. Data is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
        end else if (push) begin
            full     <= 1'b1;
            out_data <= grant_data;
            out_ch   <= grant;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb
// Directed, table-driven bench for mux_arb (NR_CH=4, DATA_LEN=2) plus
// hand-written backpressure, reset and round-robin sequences.
// Channel data is fixed: ch0=0, ch1=1, ch2=3, ch3=2.
module tb_mux_arb;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       mode      = 1'b0;
    logic [1:0] sel       = 2'd0;
    logic [3:0] in_valid  = 4'b0000;
    logic [3:0] in_ready;
    logic [7:0] in_data   = 8'hB4;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;
    logic [1:0] out_ch;

    int errors = 0;
    int checks = 0;

`ifdef MUX_ARB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic       exp_ovalid;
        logic [1:0] exp_data;
        logic [1:0] exp_ch;
        string      name;
    } vec_t;

    vec_t tbl [13];

    mux_arb #(.NR_CH(4), .DATA_LEN(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] chData(input int ch);
        case (ch % 4)
            0:       return 2'd0;
            1:       return 2'd1;
            2:       return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    task automatic applyStimulus(input logic m, input logic [1:0] s,
                                 input logic [3:0] v, input logic ordy);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOut(input string name, input logic v,
                            input logic [1:0] d, input logic [1:0] c);
        checkOutput({name, ".out_valid"}, 32'(out_valid), 32'(v));
        checkOutput({name, ".out_data"},  32'(out_data),  32'(d));
        checkOutput({name, ".out_ch"},    32'(out_ch),    32'(c));
    endtask

    initial begin
        // mode, sel, valid, exp in_ready, exp out_valid/data/ch after edge
        tbl[0]  = '{1'b0, 2'd2, 4'b1111, 4'b0100, 1'b1, 2'd3, 2'd2, "key_sel2"};
        tbl[1]  = '{1'b0, 2'd1, 4'b1101, 4'b0000, 1'b0, 2'd3, 2'd2, "key_sel1_invalid"};
        tbl[2]  = '{1'b0, 2'd1, 4'b1111, 4'b0010, 1'b1, 2'd1, 2'd1, "key_sel1_valid"};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 4'b0100, 1'b1, 2'd3, 2'd2, "rr_after1"};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 4'b1000, 1'b1, 2'd2, 2'd3, "rr_after2"};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0, 2'd0, "rr_wrap"};
        tbl[6]  = '{1'b1, 2'd0, 4'b1010, 4'b0010, 1'b1, 2'd1, 2'd1, "rr_sparse1"};
        tbl[7]  = '{1'b1, 2'd0, 4'b1010, 4'b1000, 1'b1, 2'd2, 2'd3, "rr_sparse3"};
        tbl[8]  = '{1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd2, 2'd3, "rr_idle"};
        tbl[9]  = '{1'b1, 2'd0, 4'b1010, 4'b0010, 1'b1, 2'd1, 2'd1, "switch_rr_ch1"};
        tbl[10] = '{1'b0, 2'd3, 4'b1111, 4'b1000, 1'b1, 2'd2, 2'd3, "switch_key_ch3"};
        tbl[11] = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0, 2'd0, "switch_rr_ch0"};
        tbl[12] = '{1'b0, 2'd3, 4'b0111, 4'b0000, 1'b0, 2'd0, 2'd0, "key_sel3_invalid"};

        // Reset state, with all channels requesting
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        #2;
        checkOut("reset", 1'b0, 2'd0, 2'd0);
        checkOutput("reset.in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].mode, tbl[i].sel, tbl[i].valid, 1'b1);
            checkOutput({tbl[i].name, ".in_ready"}, 32'(in_ready), 32'(tbl[i].exp_ready));
            tick();
            checkOut(tbl[i].name, tbl[i].exp_ovalid, tbl[i].exp_data, tbl[i].exp_ch);
        end

        // Backpressure: load ch2, then stall the consumer for 5 cycles
        applyStimulus(1'b0, 2'd2, 4'b1111, 1'b1);
        tick();
        checkOut("bp_load", 1'b1, 2'd3, 2'd2);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 2'd0, 4'b1111, 1'b0);
            checkOutput($sformatf("bp_stall%0d.in_ready", k), 32'(in_ready),
                        (SKID && k == 0) ? 32'h1 : 32'h0);
            tick();
            checkOut($sformatf("bp_stall%0d", k), 1'b1, 2'd3, 2'd2);
        end
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
        tick();
        if (SKID)
            checkOut("bp_drain_second", 1'b1, 2'd0, 2'd0);
        else
            checkOutput("bp_drain_empty.out_valid", 32'(out_valid), 32'h0);
        tick();
        checkOutput("bp_drained.out_valid", 32'(out_valid), 32'h0);

        // Asynchronous reset mid-stream
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        tick();
        checkOutput("pre_reset.out_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOut("async_reset", 1'b0, 2'd0, 2'd0);
        checkOutput("async_reset.in_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        checkOutput("held_reset.out_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;

        // Round-robin from a fresh pointer: 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
            checkOutput($sformatf("rr_all%0d.in_ready", i), 32'(in_ready), 32'(1 << (i % 4)));
            tick();
            checkOut($sformatf("rr_all%0d", i), 1'b1, chData(i % 4), 2'(i % 4));
        end

        // Sparse requests 4'b1010: 1,3,1,3
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
            tick();
            checkOut($sformatf("rr_sparse_seq%0d", i), 1'b1,
                     chData((i % 2) ? 3 : 1), (i % 2) ? 2'd3 : 2'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
